// File: rtl/uart_receiver.sv
// 8N1 UART receiver with a one-byte valid/ready output register.
// Mid-bit sampling from a falling start edge; reports framing errors and dropped bytes.
module uart_receiver #(
  parameter int unsigned CLOCK_FREQ = 125_000_000,
  parameter int unsigned BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       framing_error,
  output logic       overrun
);

  localparam int unsigned SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
  localparam int unsigned CW               = $clog2(SYMBOL_EDGE_TIME);
  localparam logic [CW-1:0] SAMPLE_LAST    = CW'(SAMPLE_TIME - 1);
  localparam logic [CW-1:0] SYMBOL_LAST    = CW'(SYMBOL_EDGE_TIME - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e        r_state;
  logic          r_sync1;
  logic          r_rx_s;
  logic          r_rx_d;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_framing_error;
  logic          r_overrun;

  state_e        w_state_next;
  logic [CW-1:0] w_cnt_next;
  logic [2:0]    w_bit_idx_next;
  logic [7:0]    w_shift_next;
  logic          w_complete;
  logic          w_frame_err;
  logic [7:0]    w_data_next;
  logic          w_valid_next;
  logic          w_overrun_next;

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt + 1'b1;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_complete     = 1'b0;
    w_frame_err    = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_cnt_next = '0;
        // Edge-triggered so a line stuck low never restarts a frame.
        if (r_rx_d && !r_rx_s) w_state_next = StStart;
      end
      StStart: begin
        if (r_cnt == SAMPLE_LAST) begin
          w_cnt_next     = '0;
          w_bit_idx_next = '0;
          w_state_next   = r_rx_s ? StIdle : StData;
        end
      end
      StData: begin
        if (r_cnt == SYMBOL_LAST) begin
          w_cnt_next     = '0;
          w_shift_next   = {r_rx_s, r_shift[7:1]};
          w_bit_idx_next = r_bit_idx + 1'b1;
          if (r_bit_idx == 3'd7) w_state_next = StStop;
        end
      end
      StStop: begin
        if (r_cnt == SYMBOL_LAST) begin
          w_cnt_next   = '0;
          w_state_next = StIdle;
          w_complete   = r_rx_s;
          w_frame_err  = !r_rx_s;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_data_next    = r_data;
    w_valid_next   = r_valid;
    w_overrun_next = 1'b0;
    if (w_complete) begin
      // A held byte wins over a new one unless it is being consumed this cycle.
      if (!r_valid || data_out_ready) begin
        w_data_next  = r_shift;
        w_valid_next = 1'b1;
      end else begin
        w_overrun_next = 1'b1;
      end
    end else if (r_valid && data_out_ready) begin
      w_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state         <= StIdle;
      r_sync1         <= 1'b1;
      r_rx_s          <= 1'b1;
      r_rx_d          <= 1'b1;
      r_cnt           <= '0;
      r_bit_idx       <= '0;
      r_shift         <= '0;
      r_data          <= '0;
      r_valid         <= 1'b0;
      r_framing_error <= 1'b0;
      r_overrun       <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_sync1         <= serial_in;
      r_rx_s          <= r_sync1;
      r_rx_d          <= r_rx_s;
      r_cnt           <= w_cnt_next;
      r_bit_idx       <= w_bit_idx_next;
      r_shift         <= w_shift_next;
      r_data          <= w_data_next;
      r_valid         <= w_valid_next;
      r_framing_error <= w_frame_err;
      r_overrun       <= w_overrun_next;
    end
  end

  assign data_out       = r_data;
  assign data_out_valid = r_valid;
  assign framing_error  = r_framing_error;
  assign overrun        = r_overrun;

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameters SHALL be declared one per line: name, default, meaning:
- CLOCK_FREQ, 125_000_000, clk frequency in Hz.
- BAUD_RATE, 115_200, serial bit rate in bits/s.
REQ-002 Derived constants SHALL be:
- SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE (1085 at default).
- SAMPLE_TIME = SYMBOL_EDGE_TIME / 2 (542 at default).
- Counter width = $clog2(SYMBOL_EDGE_TIME).
REQ-003 Ports SHALL be declared one per line: name, direction, width, meaning:
- clk  input  1  single clock; all logic on its rising edge.
- reset  input  1  synchronous, active-low reset; low at a clk edge resets the block.
- serial_in  input  1  asynchronous UART line; idles high; 8N1 framing, LSB first.
- data_out  output  8  received byte.
- data_out_valid  output  1  data_out holds an unconsumed byte.
- data_out_ready  input  1  consumer accepts data_out.
- framing_error  output  1  one-cycle pulse when a stop bit samples low.
- overrun  output  1  one-cycle pulse when a completed byte is dropped.

Function
REQ-004 serial_in SHALL pass through a 2-flop synchronizer, both flops reset to 1. All references below are to the synchronized value rx_s and its one-cycle-delayed copy rx_d (reset 1).
REQ-005 The FSM SHALL have the states IDLE, START, DATA and STOP.
REQ-006 IDLE SHALL detect a start only on a falling edge (rx_d=1, rx_s=0), then enter START with the clock counter at 0. A line held low SHALL never retrigger.
REQ-007 START SHALL sample rx_s when the counter reaches SAMPLE_TIME-1:
- rx_s=1: treat as a glitch, return to IDLE, no output.
- rx_s=0: enter DATA with counter and bit index cleared.
REQ-008 DATA SHALL sample rx_s each time the counter reaches SYMBOL_EDGE_TIME-1, then clear the counter.
- Bits are shifted in LSB first.
- After the 8th sample the FSM enters STOP.
REQ-009 STOP SHALL sample rx_s at counter SYMBOL_EDGE_TIME-1, then return to IDLE in the next cycle.
- rx_s=1: byte complete.
- rx_s=0: framing_error high for exactly one cycle; the byte is discarded; data_out_valid is unaffected.
REQ-010 Byte completion and a data_out_valid update SHALL be the same event: data_out_valid rises on the clk edge after the stop sample. The stop sample occurs SAMPLE_TIME + 9*SYMBOL_EDGE_TIME cycles after the start edge is detected.
REQ-011 data_out and data_out_valid SHALL stay stable while data_out_valid=1 and data_out_ready=0.
REQ-012 A transfer occurs when data_out_valid and data_out_ready are both 1 at a clk edge. data_out_valid SHALL clear on that edge unless REQ-013 applies.
REQ-013 When a completion coincides with a transfer, the new byte SHALL load into data_out and data_out_valid SHALL stay 1. No overrun is signalled.
REQ-014 When a completion occurs while data_out_valid=1 and data_out_ready=0:
- The new byte SHALL be dropped and the old byte retained.
- overrun SHALL pulse high for one cycle.
REQ-015 Reception SHALL continue regardless of output backpressure; the receiver never stalls the line.
REQ-016 data_out_ready SHALL be ignored while data_out_valid=0.

Reset
REQ-017 With reset low at a clk edge, the block SHALL on that edge:
- return the FSM to IDLE;
- clear the counter, bit index and shift register;
- set the synchronizer flops and rx_d to 1;
- drive data_out=8'h00, data_out_valid=0, framing_error=0, overrun=0.
REQ-018 Reset mid-frame SHALL abandon the frame with no output. Reception SHALL resume only on a fresh falling edge after reset deasserts.

Verification (CLOCK_FREQ=1_000_000, BAUD_RATE=100_000: SYMBOL_EDGE_TIME=10, SAMPLE_TIME=5)
REQ-019 Scenario: send 8'hA5 (10-cycle bits), data_out_ready=1 -> data_out=8'hA5 with a single-cycle valid; framing_error=0.
REQ-020 Scenario: send 8'h3C, ready=0 for 200 cycles -> valid stays 1 and data_out stays 8'h3C; valid clears on the cycle after ready rises.
REQ-021 Scenario: send 8'h11 then 8'h22 back-to-back, ready=0 -> data_out=8'h11, one overrun pulse at the second stop sample.
REQ-022 Scenario: send 8'h55 with the stop bit driven 0, then hold the line low for 50 cycles -> one framing_error pulse, valid stays 0, no further start detected until the line rises then falls.
REQ-023 Scenario: a 3-cycle low glitch on an idle line -> FSM returns to IDLE after START, no valid, no error pulses.
REQ-024 Scenario: assert reset low during bit 4 of 8'hF0, release, then send 8'h0F -> only 8'h0F is delivered.
